// File: rtl/rad_jtag_stream_if.sv
// Signal bundle for rad_jtag_stream: command stream in, TDO stream out,
// status/control, and the WISHBONE master bus toward the ID/control block.
// The master modport is the streamer's view; slave is the environment's view.
interface rad_jtag_stream_if;
  // command stream
  logic        cmd_valid_i;
  logic        cmd_ready_o;
  logic [7:0]  cmd_tdi_i;
  logic [7:0]  cmd_tms_i;
  logic [2:0]  cmd_nbits_i;
  logic        cmd_capture_i;
  // TDO return stream
  logic        tdo_valid_o;
  logic        tdo_ready_i;
  logic [7:0]  tdo_data_o;
  // status / control
  logic        busy_o;
  logic        err_o;
  logic        err_clr_i;
  // WISHBONE master
  logic        wbm_cyc_o;
  logic        wbm_stb_o;
  logic        wbm_we_o;
  logic [15:0] wbm_adr_o;
  logic [31:0] wbm_dat_o;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_dat_i;
  logic        wbm_ack_i;
  logic        wbm_err_i;
  logic        wbm_rty_i;

  modport master (
    input  cmd_valid_i, cmd_tdi_i, cmd_tms_i, cmd_nbits_i, cmd_capture_i,
    output cmd_ready_o,
    output tdo_valid_o, tdo_data_o,
    input  tdo_ready_i,
    output busy_o, err_o,
    input  err_clr_i,
    output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_adr_o, wbm_dat_o, wbm_sel_o,
    input  wbm_dat_i, wbm_ack_i, wbm_err_i, wbm_rty_i
  );

  modport slave (
    output cmd_valid_i, cmd_tdi_i, cmd_tms_i, cmd_nbits_i, cmd_capture_i,
    input  cmd_ready_o,
    input  tdo_valid_o, tdo_data_o,
    output tdo_ready_i,
    input  busy_o, err_o,
    output err_clr_i,
    input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_adr_o, wbm_dat_o, wbm_sel_o,
    output wbm_dat_i, wbm_ack_i, wbm_err_i, wbm_rty_i
  );
endinterface

// File: rtl/rad_jtag_stream.sv
// rad_jtag_stream: WISHBONE master that pushes {TMS,TDI} byte commands into the
// JTAG bit-bang register of the ID/control block, polls until the running bit
// (bit 31) clears, and optionally returns the captured TDO byte.
// One command in flight; every output is registered.
module rad_jtag_stream #(
  parameter int          SIDE        = 0,
  parameter logic [15:0] BASE_ADDR   = 16'h0000,
  parameter int          ACK_TIMEOUT = 255,
  parameter int          POLL_LIMIT  = 1023
) (
  input  logic clk_i,
  input  logic rst_n_i,
  rad_jtag_stream_if.master bus
);

  localparam logic [15:0] OFFSET   = (SIDE == 0) ? 16'h001C : 16'h0020;
  localparam logic [15:0] REG_ADDR = BASE_ADDR + OFFSET;
  localparam int ACW = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT + 1);
  localparam int PCW = (POLL_LIMIT < 2) ? 1 : $clog2(POLL_LIMIT + 1);
  localparam logic [ACW-1:0] ACK_LAST  = ACW'(ACK_TIMEOUT - 1);
  localparam logic [PCW-1:0] POLL_LAST = PCW'(POLL_LIMIT - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WRITE = 3'd1,
    S_GAP   = 3'd2,
    S_POLL  = 3'd3,
    S_OUT   = 3'd4
  } state_t;

  // Command word: start bit, nbits, TMS byte, TDI byte.
  function automatic logic [31:0] pack_cmd(input logic [2:0] nbits,
                                           input logic [7:0] tms,
                                           input logic [7:0] tdi);
    return {1'b1, 4'b0000, nbits, 8'h00, tms, tdi};
  endfunction

  state_t          r_state;
  logic            r_capture;
  logic [ACW-1:0]  r_ack_cnt;
  logic [PCW-1:0]  r_poll_cnt;

  logic            r_cmd_ready;
  logic            r_tdo_valid;
  logic [7:0]      r_tdo_data;
  logic            r_busy;
  logic            r_err;
  logic            r_cyc;
  logic            r_stb;
  logic            r_we;
  logic [15:0]     r_adr;
  logic [31:0]     r_dat;
  logic [3:0]      r_sel;

  state_t          w_state_nxt;
  logic [ACW-1:0]  w_ack_cnt_nxt;
  logic [PCW-1:0]  w_poll_cnt_nxt;
  logic            w_new_err;
  logic            w_latch_tdo;
  logic            w_accept;
  logic            w_bus_ack;
  logic            w_bus_fail;
  logic            w_timeout;
  logic            w_poll_over;
  logic            w_abort;
  logic            w_running;

  logic            w_err_nxt;
  logic            w_tdo_valid_nxt;
  logic            w_cmd_ready_nxt;
  logic [7:0]      w_tdo_data_nxt;
  logic            w_cyc_nxt;
  logic            w_we_nxt;
  logic [15:0]     w_adr_nxt;
  logic [31:0]     w_dat_nxt;
  logic [3:0]      w_sel_nxt;

  assign w_accept    = bus.cmd_valid_i & r_cmd_ready;
  assign w_running   = bus.wbm_dat_i[31];
  assign w_bus_ack   = r_stb & bus.wbm_ack_i;
  // Retry is not supported by the target, so it is treated as a bus error.
  assign w_bus_fail  = r_stb & (bus.wbm_err_i | bus.wbm_rty_i);
  assign w_timeout   = r_stb & ~bus.wbm_ack_i & (r_ack_cnt == ACK_LAST);
  assign w_poll_over = (r_state == S_POLL) & w_bus_ack & w_running &
                       (r_poll_cnt == POLL_LAST);
  assign w_abort     = w_bus_fail | w_timeout | w_poll_over;

  // Sequencer next state, poll counter update and error/TDO capture strobes.
  always_comb begin
    w_state_nxt    = r_state;
    w_poll_cnt_nxt = r_poll_cnt;
    w_new_err      = 1'b0;
    w_latch_tdo    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_nxt    = S_WRITE;
          w_poll_cnt_nxt = {PCW{1'b0}};
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_WRITE: begin
        if (w_abort) begin
          w_state_nxt = S_IDLE;
          w_new_err   = 1'b1;
        end else if (w_bus_ack) begin
          w_state_nxt = S_GAP;
        end else begin
          w_state_nxt = S_WRITE;
        end
      end
      // One idle bus cycle so the running bit is already set when we read.
      S_GAP: begin
        w_state_nxt = S_POLL;
      end
      S_POLL: begin
        if (w_abort) begin
          w_state_nxt = S_IDLE;
          w_new_err   = 1'b1;
        end else if (w_bus_ack) begin
          if (w_running) begin
            w_poll_cnt_nxt = r_poll_cnt + PCW'(1);
            w_state_nxt    = S_GAP;
          end else begin
            w_latch_tdo = r_capture;
            w_state_nxt = r_capture ? S_OUT : S_IDLE;
          end
        end else begin
          w_state_nxt = S_POLL;
        end
      end
      S_OUT: begin
        if (bus.tdo_ready_i) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_OUT;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Next values of the registered outputs, derived from the next state.
  always_comb begin
    w_ack_cnt_nxt   = {ACW{1'b0}};
    w_err_nxt       = r_err;
    w_tdo_data_nxt  = r_tdo_data;
    w_dat_nxt       = 32'h0000_0000;
    w_sel_nxt       = 4'h0;

    if (r_stb && !bus.wbm_ack_i && !w_abort) begin
      w_ack_cnt_nxt = r_ack_cnt + ACW'(1);
    end else begin
      w_ack_cnt_nxt = {ACW{1'b0}};
    end

    // Clear wins over an error raised in the same cycle.
    if (bus.err_clr_i) begin
      w_err_nxt = 1'b0;
    end else begin
      w_err_nxt = r_err | w_new_err;
    end

    if (w_latch_tdo) begin
      w_tdo_data_nxt = bus.wbm_dat_i[23:16];
    end else begin
      w_tdo_data_nxt = r_tdo_data;
    end

    w_cyc_nxt       = (w_state_nxt == S_WRITE) || (w_state_nxt == S_POLL);
    w_we_nxt        = (w_state_nxt == S_WRITE);
    w_adr_nxt       = w_cyc_nxt ? REG_ADDR : 16'h0000;
    w_tdo_valid_nxt = (w_state_nxt == S_OUT);
    w_cmd_ready_nxt = (w_state_nxt == S_IDLE) && !w_err_nxt && !w_tdo_valid_nxt;

    case (w_state_nxt)
      S_WRITE: begin
        // Fields come straight from the stream on the accepting cycle.
        if (r_state == S_IDLE) begin
          w_dat_nxt = pack_cmd(bus.cmd_nbits_i, bus.cmd_tms_i, bus.cmd_tdi_i);
        end else begin
          w_dat_nxt = r_dat;
        end
        w_sel_nxt = 4'b1011;
      end
      S_POLL: begin
        w_dat_nxt = 32'h0000_0000;
        w_sel_nxt = 4'hF;
      end
      default: begin
        w_dat_nxt = 32'h0000_0000;
        w_sel_nxt = 4'h0;
      end
    endcase
  end

  // State, counters, latched command flag and all registered outputs.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state     <= S_IDLE;
      r_capture   <= 1'b0;
      r_ack_cnt   <= {ACW{1'b0}};
      r_poll_cnt  <= {PCW{1'b0}};
      r_cmd_ready <= 1'b0;
      r_tdo_valid <= 1'b0;
      r_tdo_data  <= 8'h00;
      r_busy      <= 1'b0;
      r_err       <= 1'b0;
      r_cyc       <= 1'b0;
      r_stb       <= 1'b0;
      r_we        <= 1'b0;
      r_adr       <= 16'h0000;
      r_dat       <= 32'h0000_0000;
      r_sel       <= 4'h0;
    end else begin
      r_state     <= w_state_nxt;
      if (w_accept) begin
        r_capture <= bus.cmd_capture_i;
      end
      r_ack_cnt   <= w_ack_cnt_nxt;
      r_poll_cnt  <= w_poll_cnt_nxt;
      r_cmd_ready <= w_cmd_ready_nxt;
      r_tdo_valid <= w_tdo_valid_nxt;
      r_tdo_data  <= w_tdo_data_nxt;
      r_busy      <= (w_state_nxt != S_IDLE);
      r_err       <= w_err_nxt;
      r_cyc       <= w_cyc_nxt;
      r_stb       <= w_cyc_nxt;
      r_we        <= w_we_nxt;
      r_adr       <= w_adr_nxt;
      r_dat       <= w_dat_nxt;
      r_sel       <= w_sel_nxt;
    end
  end

  assign bus.cmd_ready_o = r_cmd_ready;
  assign bus.tdo_valid_o = r_tdo_valid;
  assign bus.tdo_data_o  = r_tdo_data;
  assign bus.busy_o      = r_busy;
  assign bus.err_o       = r_err;
  assign bus.wbm_cyc_o   = r_cyc;
  assign bus.wbm_stb_o   = r_stb;
  assign bus.wbm_we_o    = r_we;
  assign bus.wbm_adr_o   = r_adr;
  assign bus.wbm_dat_o   = r_dat;
  assign bus.wbm_sel_o   = r_sel;

endmodule

// File: tb/tb_rad_jtag_stream.sv
// Directed bench for rad_jtag_stream: a scripted WISHBONE slave plays the
// JTAG register (configurable busy count, stuck-busy, no-ack), and each
// expected value below is worked out by hand from the command encoding.
module tb_rad_jtag_stream;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rad_jtag_stream_if u_if();
  rad_jtag_stream_if u_if2();

  rad_jtag_stream #(.SIDE(0), .BASE_ADDR(16'h0000), .ACK_TIMEOUT(255), .POLL_LIMIT(1023))
    u_dut (.clk_i(clk), .rst_n_i(rst_n), .bus(u_if.master));

  rad_jtag_stream #(.SIDE(1), .BASE_ADDR(16'h0400), .ACK_TIMEOUT(255), .POLL_LIMIT(1023))
    u_dut2 (.clk_i(clk), .rst_n_i(rst_n), .bus(u_if2.master));

  int n_cmp = 0;
  int n_err = 0;

  // slave model state for u_dut
  int          cyc_no = 0;
  int          wr_cnt = 0;
  int          rd_cnt = 0;
  int          busy_cfg = 0;
  int          busy_left = 0;
  bit          stuck = 1'b0;
  bit          no_ack = 1'b0;
  logic [31:0] done_word = 32'h0;
  logic [31:0] wr_dat = 32'h0;
  logic [3:0]  wr_sel = 4'h0;
  logic [3:0]  rd_sel = 4'h0;
  logic [15:0] wr_adr = 16'h0;
  logic [15:0] rd_adr = 16'h0;
  int          done_cyc = 0;
  int          wr_delta = 0;
  int          stb_cycles = 0;
  bit          tdo_seen = 1'b0;

  // slave model state for u_dut2
  logic [15:0] adr2_wr = 16'h0;
  logic [15:0] adr2_rd = 16'h0;
  int          rd2_cnt = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Scripted register slave for u_dut; acts on the falling edge.
  initial begin
    u_if.wbm_ack_i = 1'b0;
    u_if.wbm_dat_i = 32'h0;
    u_if.wbm_err_i = 1'b0;
    u_if.wbm_rty_i = 1'b0;
    forever begin
      @(negedge clk);
      cyc_no++;
      if (u_if.wbm_stb_o) stb_cycles++;
      if (u_if.tdo_valid_o) tdo_seen = 1'b1;
      if (u_if.wbm_cyc_o && u_if.wbm_stb_o && !u_if.wbm_ack_i && !no_ack) begin
        u_if.wbm_ack_i = 1'b1;
        if (u_if.wbm_we_o) begin
          wr_cnt++;
          wr_dat    = u_if.wbm_dat_o;
          wr_sel    = u_if.wbm_sel_o;
          wr_adr    = u_if.wbm_adr_o;
          busy_left = busy_cfg;
          wr_delta  = cyc_no - done_cyc;
          u_if.wbm_dat_i = 32'h0;
        end else begin
          rd_cnt++;
          rd_sel = u_if.wbm_sel_o;
          rd_adr = u_if.wbm_adr_o;
          if (stuck || busy_left > 0) begin
            u_if.wbm_dat_i = 32'h8000_0000;
            if (busy_left > 0) busy_left--;
          end else begin
            u_if.wbm_dat_i = done_word;
            done_cyc = cyc_no;
          end
        end
      end else begin
        u_if.wbm_ack_i = 1'b0;
        u_if.wbm_dat_i = 32'h0;
      end
    end
  end

  // Always-ready slave for u_dut2 that never reports running.
  initial begin
    u_if2.wbm_ack_i = 1'b0;
    u_if2.wbm_dat_i = 32'h0;
    u_if2.wbm_err_i = 1'b0;
    u_if2.wbm_rty_i = 1'b0;
    forever begin
      @(negedge clk);
      if (u_if2.wbm_cyc_o && u_if2.wbm_stb_o && !u_if2.wbm_ack_i) begin
        u_if2.wbm_ack_i = 1'b1;
        if (u_if2.wbm_we_o) adr2_wr = u_if2.wbm_adr_o;
        else begin
          adr2_rd = u_if2.wbm_adr_o;
          rd2_cnt++;
        end
      end else begin
        u_if2.wbm_ack_i = 1'b0;
      end
    end
  end

  task automatic send_cmd(input logic [7:0] tdi, input logic [7:0] tms,
                          input logic [2:0] nbits, input logic cap);
    int n;
    @(negedge clk);
    u_if.cmd_tdi_i     = tdi;
    u_if.cmd_tms_i     = tms;
    u_if.cmd_nbits_i   = nbits;
    u_if.cmd_capture_i = cap;
    u_if.cmd_valid_i   = 1'b1;
    n = 0;
    while (!u_if.cmd_ready_o && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) check_eq("accept_timeout", 64'(u_if.cmd_ready_o), 64'd1);
    else @(posedge clk);
    #1 u_if.cmd_valid_i = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int limit);
    int n;
    n = 0;
    do begin
      @(negedge clk); #1;
      n++;
    end while ((u_if.busy_o || !u_if.cmd_ready_o) && n < limit);
    if (n >= limit) check_eq(tag, 64'(u_if.busy_o), 64'd0);
  endtask

  task automatic wait_err(input string tag, input int limit);
    int n;
    n = 0;
    do begin
      @(negedge clk); #1;
      n++;
    end while (!u_if.err_o && n < limit);
    if (n >= limit) check_eq(tag, 64'(u_if.err_o), 64'd1);
  endtask

  task automatic clear_err();
    @(negedge clk);
    u_if.err_clr_i = 1'b1;
    @(negedge clk);
    u_if.err_clr_i = 1'b0;
    #1;
  endtask

  initial begin
    int n;
    u_if.cmd_valid_i = 1'b0;  u_if.cmd_tdi_i = 8'h00; u_if.cmd_tms_i = 8'h00;
    u_if.cmd_nbits_i = 3'd0;  u_if.cmd_capture_i = 1'b0;
    u_if.tdo_ready_i = 1'b0;  u_if.err_clr_i = 1'b0;
    u_if2.cmd_valid_i = 1'b0; u_if2.cmd_tdi_i = 8'h00; u_if2.cmd_tms_i = 8'h00;
    u_if2.cmd_nbits_i = 3'd0; u_if2.cmd_capture_i = 1'b0;
    u_if2.tdo_ready_i = 1'b0; u_if2.err_clr_i = 1'b0;

    // reset state
    repeat (3) @(negedge clk);
    #1;
    check_eq("rst_ctl", {u_if.cmd_ready_o, u_if.tdo_valid_o, u_if.busy_o, u_if.err_o,
                         u_if.wbm_cyc_o, u_if.wbm_stb_o, u_if.wbm_we_o, u_if.wbm_sel_o,
                         u_if.tdo_data_o}, 64'd0);
    check_eq("rst_bus", {u_if.wbm_adr_o, u_if.wbm_dat_o}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk); #1;
    check_eq("idle_ready", 64'(u_if.cmd_ready_o), 64'd1);

    // right-core instance at BASE 0x0400 addresses 0x0420
    u_if2.cmd_tdi_i = 8'h5A; u_if2.cmd_nbits_i = 3'd7; u_if2.cmd_valid_i = 1'b1;
    n = 0;
    while (!u_if2.cmd_ready_o && n < 50) begin @(negedge clk); n++; end
    @(posedge clk); #1 u_if2.cmd_valid_i = 1'b0;
    repeat (10) @(negedge clk);
    #1;
    check_eq("side1_wr_adr", 64'(adr2_wr), 64'h0420);
    check_eq("side1_rd_adr", 64'(adr2_rd), 64'h0420);
    check_eq("side1_rd_cnt", 64'(rd2_cnt), 64'd1);

    // A5 with 3 busy polls, capture 3C
    busy_cfg = 3; done_word = 32'h003C_0000; wr_cnt = 0; rd_cnt = 0;
    send_cmd(8'hA5, 8'h00, 3'd7, 1'b1);
    n = 0;
    do begin @(negedge clk); #1; n++; end while (!u_if.tdo_valid_o && n < 200);
    check_eq("t1_tdo_valid", 64'(u_if.tdo_valid_o), 64'd1);
    check_eq("t1_tdo_data", 64'(u_if.tdo_data_o), 64'h3C);
    check_eq("t1_wr_cnt", 64'(wr_cnt), 64'd1);
    check_eq("t1_wr_dat", 64'(wr_dat), 64'h8700_00A5);
    check_eq("t1_wr_sel", 64'(wr_sel), 64'hB);
    check_eq("t1_wr_adr", 64'(wr_adr), 64'h001C);
    check_eq("t1_rd_cnt", 64'(rd_cnt), 64'd4);
    check_eq("t1_rd_sel", 64'(rd_sel), 64'hF);
    check_eq("t1_rd_adr", 64'(rd_adr), 64'h001C);

    // TDO back-pressure: valid/data hold, no new command accepted
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); #1;
      check_eq("bp_valid", 64'(u_if.tdo_valid_o), 64'd1);
      check_eq("bp_data", 64'(u_if.tdo_data_o), 64'h3C);
      check_eq("bp_ready", 64'(u_if.cmd_ready_o), 64'd0);
    end
    u_if.tdo_ready_i = 1'b1;
    @(negedge clk);
    u_if.tdo_ready_i = 1'b0;
    #1;
    check_eq("bp_done_valid", 64'(u_if.tdo_valid_o), 64'd0);
    check_eq("bp_done_ready", 64'(u_if.cmd_ready_o), 64'd1);

    // back-to-back capture=0: 2 polls each, one idle cycle between commands
    busy_cfg = 1; wr_cnt = 0; rd_cnt = 0; tdo_seen = 1'b0; done_word = 32'h00EE_0000;
    send_cmd(8'h11, 8'h03, 3'd3, 1'b0);
    send_cmd(8'h22, 8'h01, 3'd2, 1'b0);
    wait_idle("t3_idle_timeout", 100);
    check_eq("t3_wr_cnt", 64'(wr_cnt), 64'd2);
    check_eq("t3_rd_cnt", 64'(rd_cnt), 64'd4);
    check_eq("t3_wr_dat", 64'(wr_dat), 64'h8200_0122);
    // final poll ack seen on one falling edge, write ack two falling edges later
    check_eq("t3_wr_delta", 64'(wr_delta), 64'd2);
    check_eq("t3_no_tdo", 64'(tdo_seen), 64'd0);
    check_eq("t3_data_hold", 64'(u_if.tdo_data_o), 64'h3C);

    // slave never acks: abort after 255 strobe cycles
    no_ack = 1'b1; stb_cycles = 0;
    send_cmd(8'h01, 8'h01, 3'd0, 1'b1);
    wait_err("t4_err_timeout", 600);
    check_eq("t4_stb_cycles", 64'(stb_cycles), 64'd255);
    check_eq("t4_cyc", 64'(u_if.wbm_cyc_o), 64'd0);
    check_eq("t4_ready", 64'(u_if.cmd_ready_o), 64'd0);
    no_ack = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check_eq("t4_err_sticky", 64'({u_if.err_o, u_if.cmd_ready_o}), 64'b10);
    clear_err();
    check_eq("t4_clr_err", 64'(u_if.err_o), 64'd0);
    check_eq("t4_clr_ready", 64'(u_if.cmd_ready_o), 64'd1);

    // running bit stuck: abort after 1023 polls, no TDO
    stuck = 1'b1; rd_cnt = 0; tdo_seen = 1'b0;
    send_cmd(8'h0F, 8'h00, 3'd3, 1'b1);
    wait_err("t5_err_timeout", 5000);
    check_eq("t5_rd_cnt", 64'(rd_cnt), 64'd1023);
    check_eq("t5_no_tdo", 64'(tdo_seen), 64'd0);
    check_eq("t5_cyc", 64'(u_if.wbm_cyc_o), 64'd0);
    stuck = 1'b0;
    clear_err();
    check_eq("t5_clr_ready", 64'(u_if.cmd_ready_o), 64'd1);

    // reset asserted in the middle of polling
    busy_cfg = 5;
    send_cmd(8'hC3, 8'h00, 3'd7, 1'b1);
    n = 0;
    do begin @(negedge clk); #1; n++; end
      while (!(u_if.wbm_cyc_o && !u_if.wbm_we_o) && n < 50);
    check_eq("t6_in_poll", 64'({u_if.wbm_cyc_o, u_if.wbm_we_o}), 64'b10);
    rst_n = 1'b0;
    #1;
    check_eq("t6_rst_ctl", {u_if.cmd_ready_o, u_if.tdo_valid_o, u_if.busy_o, u_if.err_o,
                            u_if.wbm_cyc_o, u_if.wbm_stb_o, u_if.wbm_we_o, u_if.wbm_sel_o,
                            u_if.tdo_data_o}, 64'd0);
    check_eq("t6_rst_bus", {u_if.wbm_adr_o, u_if.wbm_dat_o}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk); #1;
    check_eq("t6_post_ready", 64'(u_if.cmd_ready_o), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
